// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin sharing of one sign-magnitude compare unit between
// NUM_REQ requesters. Owns the compare threshold so updates never disturb an
// operation in flight. Optional WAIT-state timeout enabled by CMP_ARB_TIMEOUT_EN.
module compare_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_data,
    input  logic [NUM_REQ*16-1:0] req_iteration_data,
    input  logic [NUM_REQ*16-1:0] req_constant_data,
    input  logic [15:0]           cfg_constant,
    input  logic                  cfg_constant_we,
    output logic [15:0]           cmp_data,
    output logic [15:0]           cmp_iteration_data,
    output logic [15:0]           cmp_constant_data,
    output logic [15:0]           cmp_constant,
    output logic                  cmp_data_valid,
    input  logic                  cmp_complete,
    input  logic [15:0]           cmp_result,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_result,
    output logic                  rsp_error,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q;
    logic [ID_W-1:0] ptr_q;        // last granted requester
    logic [ID_W-1:0] id_q;         // requester of the operation in flight
    logic [15:0]     active_q;     // threshold driven to the compare unit
    logic [15:0]     pending_q;    // threshold written while busy
    logic            pending_vld_q;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] idx;

`ifdef CMP_ARB_TIMEOUT_EN
    localparam logic [3:0] TmoLast = 4'(TIMEOUT - 1);
    logic [3:0] tmo_cnt_q;
    logic       rsp_error_q;
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    assign cmp_constant = active_q;
    assign busy         = (state_q != StIdle);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((32'(ptr_q) + off) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    // Accept pulse only in IDLE; gated by reset so outputs read 0 while it is held.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && grant_found && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Control FSM, operand/result registers and threshold bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StIdle;
            ptr_q              <= ID_W'(NUM_REQ - 1);
            id_q               <= '0;
            active_q           <= '0;
            pending_q          <= '0;
            pending_vld_q      <= 1'b0;
            cmp_data           <= '0;
            cmp_iteration_data <= '0;
            cmp_constant_data  <= '0;
            cmp_data_valid     <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_id             <= '0;
            rsp_result         <= '0;
`ifdef CMP_ARB_TIMEOUT_EN
            tmo_cnt_q          <= '0;
            rsp_error_q        <= 1'b0;
`endif
        end else begin
            // Threshold: direct write in IDLE, deferred write otherwise, the
            // deferred value lands in RESP so the current operation is untouched.
            if (cfg_constant_we && (state_q == StIdle || state_q == StResp)) begin
                active_q      <= cfg_constant;
                pending_vld_q <= 1'b0;
            end else if (cfg_constant_we) begin
                pending_q     <= cfg_constant;
                pending_vld_q <= 1'b1;
            end else if (state_q == StResp && pending_vld_q) begin
                active_q      <= pending_q;
                pending_vld_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        ptr_q              <= grant_id;
                        id_q               <= grant_id;
                        cmp_data           <= req_data[{grant_id, 4'b0000} +: 16];
                        cmp_iteration_data <= req_iteration_data[{grant_id, 4'b0000} +: 16];
                        cmp_constant_data  <= req_constant_data[{grant_id, 4'b0000} +: 16];
                        cmp_data_valid     <= 1'b1;
                        state_q            <= StIssue;
                    end
                end
                StIssue: begin
                    // Strobe must be a single cycle or the compare unit re-toggles.
                    cmp_data_valid <= 1'b0;
                    state_q        <= StWait;
`ifdef CMP_ARB_TIMEOUT_EN
                    tmo_cnt_q      <= '0;
`endif
                end
                StWait: begin
                    if (cmp_complete) begin
                        rsp_result <= cmp_result;
                        rsp_id     <= id_q;
                        rsp_valid  <= 1'b1;
                        state_q    <= StResp;
`ifdef CMP_ARB_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
                    end else if (tmo_cnt_q == TmoLast) begin
                        rsp_result  <= '0;
                        rsp_id      <= id_q;
                        rsp_error_q <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 4'd1;
`endif
                    end
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
